fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Instruction fetch stage feeding the decode/control unit: owns the PC, issues imem reads, holds the
//   fetched word stable on instr until the datapath advances, then computes the next PC from decode and ALU results.
// - Sits between the instruction cache/imem port and the control unit; its instr output drives imemload.
// PARAMETERS
// - PC_RESET  32'h0000_0000  PC value loaded on reset; first fetch address
// - CNT_W     32             width of perf counters (only with FETCH_PERF_EN)
// PORTS
// - CLK        in   1   clock, all state rising-edge
// - nRST       in   1   asynchronous active-low reset
// - ihit       in   1   imem read complete; imemload_in valid this cycle
// - imemload_in in  32  instruction word from imem
// - advance    in   1   datapath consumed current instr; redirect inputs valid this cycle
// - jump       in   1   J/JAL taken
// - jr         in   1   JR taken
// - beq, bne   in   1   branch type from decode
// - zero       in   1   ALU zero flag for current instr
// - jr_target  in   32  rs value for JR
// - halt       in   1   current instr is HALT
// - imemREN    out  1   imem read request
// - imemaddr   out  32  imem address (= pc)
// - instr      out  32  held instruction to control unit
// - instr_valid out 1   instr holds a fetched, unconsumed word
// - pc_plus4   out  32  pc + 4 (JAL link value, branch base)
// - halted     out  1   fetch stopped after HALT
// BEHAVIOUR
// - States: BOOT, FETCH, ISSUE, HALTED. Reset (async, nRST=0) -> BOOT; pc=PC_RESET, instr=0,
//   instr_valid=0, halted=0, imemREN=0. Reset mid-fetch/issue discards everything, no imem request survives.
// - BOOT: one cycle, imemREN=0 -> FETCH.
// - FETCH: imemREN=1, imemaddr=pc held constant until ihit. On ihit: instr<=imemload_in, instr_valid<=1 -> ISSUE.
//   No timeout; ihit may arrive same cycle as request (1-cycle fetch latency minimum to instr_valid).
// - ISSUE: imemREN=0, instr stable. advance=0 -> stay. advance=1 -> instr_valid<=0, pc<=next_pc;
//   halt=1 -> HALTED (pc unchanged), else -> FETCH. Redirect inputs ignored outside ISSUE&advance.
// - HALTED: imemREN=0, halted=1, pc frozen; only reset exits.
// - next_pc priority: jr -> {jr_target[31:2],2'b00}; else jump -> {pc_plus4[31:28], instr[25:0], 2'b00};
//   else (beq&zero)|(bne&~zero) -> pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}; else pc_plus4.
// - Arithmetic mod 2^32: pc 32'hFFFF_FFFC + 4 wraps to 0; branch target wraps likewise, no fault.
// - halt wins over all redirects when asserted with advance. ihit outside FETCH ignored.
// - pc[1:0] always 00. imemaddr = pc in every state.
// CONFIGURATION
// - FETCH_PERF_EN defined: adds outputs fetch_count[CNT_W-1:0] (+1 per ihit accepted in FETCH) and
//   wait_count[CNT_W-1:0] (+1 per FETCH cycle without ihit); both reset to 0, wrap at 2^CNT_W, freeze in HALTED.
// - Not defined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset release, ihit=1 immediately -> BOOT 1 cycle imemREN=0, then imemaddr=0 imemREN=1; next cycle instr_valid=1.
// - Sequential: instr at 0x0, advance with no redirect -> next imemaddr=0x4, pc_plus4=0x8 after second fetch.
// - Branch: pc=0x10, instr imm16=0xFFFE, beq=1 zero=1 advance -> next imemaddr=0x0C; bne=1 zero=1 -> 0x14.
// - Jump/JR priority: pc=0x1000_0000, instr[25:0]=0x40, jump=1 jr=1 jr_target=0x203 -> imemaddr=0x200;
//   jr=0 -> 0x1000_0100.
// - Stall: ihit low 3 cycles -> imemaddr stable, imemREN=1; advance low 5 cycles in ISSUE -> instr unchanged;
//   FETCH_PERF_EN: wait_count=3, fetch_count=1.
// - Halt/reset: halt=1 advance=1 -> halted=1, imemREN=0 permanently; nRST pulse mid-FETCH -> pc=PC_RESET, instr_valid=0 immediately.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory port between the fetch stage and imem/icache.
// master = fetch side (issues requests), slave = memory side.
interface fetch_unit_if;
    logic        ihit;
    logic [31:0] imemload_in;
    logic        imemREN;
    logic [31:0] imemaddr;

    modport master (
        input  ihit,
        input  imemload_in,
        output imemREN,
        output imemaddr
    );

    modport slave (
        output ihit,
        output imemload_in,
        input  imemREN,
        input  imemaddr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem reads, holds the word.
// Optional FETCH_PERF_EN adds fetch_count / wait_count perf counters.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
`ifdef FETCH_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic         CLK,
    input  logic         nRST,
    fetch_unit_if.master imem,
    input  logic         advance,
    input  logic         jump,
    input  logic         jr,
    input  logic         beq,
    input  logic         bne,
    input  logic         zero,
    input  logic [31:0]  jr_target,
    input  logic         halt,
    output logic [31:0]  instr,
    output logic         instr_valid,
    output logic [31:0]  pc_plus4,
    output logic         halted
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] wait_count
`endif
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        ISSUE,
        HALTED
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        ren;
    logic [31:0] next_pc;
    logic [31:0] br_off;
    logic        br_taken;

    assign imem.imemREN  = ren;
    assign imem.imemaddr = pc;
    assign pc_plus4      = pc + 32'd4;

    assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign br_taken = (beq & zero) | (bne & ~zero);

    // Redirect priority: jr, then jump, then taken branch, else sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (jr)
            next_pc = jr_target & 32'hFFFF_FFFC;
        else if (jump)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (br_taken)
            next_pc = pc_plus4 + br_off;
    end

    // Fetch FSM; request, held word and halt flag are registered with it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= BOOT;
            pc          <= PC_RESET & 32'hFFFF_FFFC;
            ren         <= 1'b0;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    state <= FETCH;
                    ren   <= 1'b1;
                end
                FETCH: begin
                    if (imem.ihit) begin
                        instr       <= imem.imemload_in;
                        instr_valid <= 1'b1;
                        ren         <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (advance) begin
                        instr_valid <= 1'b0;
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            pc    <= next_pc;
                            ren   <= 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Count accepted fetches and FETCH cycles spent waiting on imem.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_count <= '0;
            wait_count  <= '0;
        end else if (state == FETCH) begin
            if (imem.ihit)
                fetch_count <= fetch_count + 1'b1;
            else
                wait_count <= wait_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a transaction-level PC model.
// Build with +define+FETCH_PERF_EN to also check the perf counters.
module tb_fetch_unit;

    logic        CLK;
    logic        nRST;
    logic        advance, jump, jr, beq, bne, zero, halt;
    logic [31:0] jr_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_plus4;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] wait_count;
`endif

    fetch_unit_if imem ();

    fetch_unit #(
        .PC_RESET(32'h0000_0000)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .imem(imem),
        .advance(advance),
        .jump(jump),
        .jr(jr),
        .beq(beq),
        .bne(bne),
        .zero(zero),
        .jr_target(jr_target),
        .halt(halt),
        .instr(instr),
        .instr_valid(instr_valid),
        .pc_plus4(pc_plus4),
        .halted(halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count(fetch_count),
        .wait_count(wait_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total;
    int passed;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int m_fetch;
    int m_wait;

    // Next PC from the instruction-set rules, using plain arithmetic.
    function automatic logic [31:0] model_next(
        input logic [31:0] pc, input logic [31:0] w,
        input logic j, input logic r, input logic bq,
        input logic bn, input logic z, input logic [31:0] t);
        logic [31:0] seq;
        int off;
        seq = pc + 32'd4;
        if (r) return t - (t % 32'd4);
        if (j) return (seq / 32'h1000_0000) * 32'h1000_0000
                      + (w % 32'h0400_0000) * 32'd4;
        if ((bq && z) || (bn && !z)) begin
            off = int'($signed(w[15:0])) * 4;
            return seq + 32'(off);
        end
        return seq;
    endfunction

    task automatic drive_idle();
        advance = 0; jump = 0; jr = 0; beq = 0; bne = 0;
        zero = 0; halt = 0; jr_target = 0;
        imem.ihit = 0; imem.imemload_in = 0;
    endtask

    task automatic drive_junk();
        advance = 1'($urandom); jump = 1'($urandom);
        jr = 1'($urandom); beq = 1'($urandom);
        bne = 1'($urandom); zero = 1'($urandom);
        halt = 1'($urandom); jr_target = $urandom;
    endtask

    task automatic boot_release();
        @(posedge CLK);
        #1 nRST = 1;
        imem.ihit = 1; imem.imemload_in = $urandom;
        @(negedge CLK);
        total++;
        if ({imem.imemREN, instr_valid, halted} !== 3'b000)
            $display("FAIL boot: REN=%0b valid=%0b halted=%0b, want 0 0 0",
                     imem.imemREN, instr_valid, halted);
        else passed++;
        m_pc = 32'h0; m_fetch = 0; m_wait = 0;
    endtask

    task automatic test_reset();
        nRST = 0;
        drive_idle();
        repeat (2) @(negedge CLK);
        total++;
        if ({imem.imemREN, imem.imemaddr, instr_valid, halted, instr}
            !== {1'b0, 32'h0, 1'b0, 1'b0, 32'h0})
            $display("FAIL reset: REN=%0b addr=%h valid=%0b halted=%0b instr=%h, want 0 0 0 0 0",
                     imem.imemREN, imem.imemaddr, instr_valid, halted, instr);
        else passed++;
`ifdef FETCH_PERF_EN
        total++;
        if ({fetch_count, wait_count} !== 64'h0)
            $display("FAIL reset_perf: fetch=%0d wait=%0d, want 0 0",
                     fetch_count, wait_count);
        else passed++;
`endif
        boot_release();
    endtask

    task automatic do_fetch(input logic [31:0] word, input int stall);
        for (int i = 0; i <= stall; i++) begin
            @(negedge CLK);
            total++;
            if ({imem.imemREN, imem.imemaddr, instr_valid, halted}
                !== {1'b1, m_pc, 1'b0, 1'b0})
                $display("FAIL fetch_req: REN=%0b addr=%h valid=%0b halted=%0b, want 1 %h 0 0",
                         imem.imemREN, imem.imemaddr, instr_valid, halted, m_pc);
            else passed++;
            total++;
            if (pc_plus4 !== m_pc + 32'd4)
                $display("FAIL pc_plus4: got %h want %h", pc_plus4, m_pc + 32'd4);
            else passed++;
            drive_junk();
            imem.ihit = (i == stall);
            imem.imemload_in = (i == stall) ? word : $urandom;
        end
        @(negedge CLK);
        total++;
        if ({instr_valid, instr, imem.imemREN, imem.imemaddr}
            !== {1'b1, word, 1'b0, m_pc})
            $display("FAIL fetch_done: valid=%0b instr=%h REN=%0b addr=%h, want 1 %h 0 %h",
                     instr_valid, instr, imem.imemREN, imem.imemaddr, word, m_pc);
        else passed++;
        drive_junk();
        advance = 0;
        imem.ihit = 1'($urandom);
        imem.imemload_in = $urandom;
        m_instr = word;
        m_fetch++;
        m_wait += stall;
    endtask

    task automatic do_issue(input int hold, input logic j, input logic r,
                            input logic bq, input logic bn, input logic z,
                            input logic [31:0] t, input logic h);
        for (int i = 0; i < hold; i++) begin
            drive_junk();
            advance = 0;
            imem.ihit = 1'($urandom);
            imem.imemload_in = $urandom;
            @(negedge CLK);
            total++;
            if ({instr_valid, instr, imem.imemREN, halted, imem.imemaddr}
                !== {1'b1, m_instr, 1'b0, 1'b0, m_pc})
                $display("FAIL issue_hold: valid=%0b instr=%h REN=%0b halted=%0b addr=%h, want 1 %h 0 0 %h",
                         instr_valid, instr, imem.imemREN, halted, imem.imemaddr, m_instr, m_pc);
            else passed++;
        end
        advance = 1; jump = j; jr = r; beq = bq; bne = bn;
        zero = z; jr_target = t; halt = h;
        if (!h) m_pc = model_next(m_pc, m_instr, j, r, bq, bn, z, t);
    endtask

    task automatic goto_pc(input logic [31:0] a);
        do_fetch($urandom, 0);
        do_issue(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a | 32'($urandom_range(0, 3)), 1'b0);
    endtask

    task automatic test_sequential();
        do_fetch($urandom, 0);
        do_issue(0, 0, 0, 0, 0, 0, $urandom, 0);
        do_fetch($urandom, 0);
        do_issue(1, 0, 0, 0, 0, 0, $urandom, 0);
    endtask

    task automatic test_branch();
        goto_pc(32'h10);
        do_fetch({16'($urandom), 16'hFFFE}, 0);
        do_issue(0, 0, 0, 1, 0, 1, $urandom, 0);
        goto_pc(32'h10);
        do_fetch({16'($urandom), 16'hFFFE}, 0);
        do_issue(0, 0, 0, 0, 1, 1, $urandom, 0);
        goto_pc(32'h10);
        do_fetch({16'($urandom), 16'h0020}, 0);
        do_issue(0, 0, 0, 0, 1, 0, $urandom, 0);
    endtask

    task automatic test_jump();
        goto_pc(32'h1000_0000);
        do_fetch({6'($urandom), 26'h40}, 0);
        do_issue(0, 1, 1, 1, 0, 1, 32'h203, 0);
        goto_pc(32'h1000_0000);
        do_fetch({6'($urandom), 26'h40}, 0);
        do_issue(0, 1, 0, 1, 0, 1, 32'h203, 0);
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        do_fetch($urandom, 1);
        do_issue(0, 0, 0, 0, 0, 0, $urandom, 0);
        goto_pc(32'hFFFF_FFF0);
        do_fetch({16'($urandom), 16'h0010}, 0);
        do_issue(0, 0, 0, 1, 0, 1, $urandom, 0);
        do_fetch($urandom, 0);
        do_issue(0, 0, 0, 0, 0, 0, $urandom, 0);
    endtask

    task automatic test_stall();
        test_reset();
        do_fetch($urandom, 3);
`ifdef FETCH_PERF_EN
        total++;
        if ({fetch_count, wait_count} !== {32'd1, 32'd3})
            $display("FAIL stall_perf: fetch=%0d wait=%0d, want 1 3",
                     fetch_count, wait_count);
        else passed++;
`endif
        do_issue(5, 0, 0, 0, 0, 0, $urandom, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            do_fetch($urandom, int'($urandom_range(0, 3)));
            do_issue(int'($urandom_range(0, 3)), 1'($urandom),
                     ($urandom_range(0, 3) == 0), 1'($urandom),
                     1'($urandom), 1'($urandom), $urandom, 1'b0);
        end
`ifdef FETCH_PERF_EN
        do_fetch($urandom, 0);
        total++;
        if ({fetch_count, wait_count} !== {32'(m_fetch), 32'(m_wait)})
            $display("FAIL random_perf: fetch=%0d wait=%0d, want %0d %0d",
                     fetch_count, wait_count, m_fetch, m_wait);
        else passed++;
        do_issue(0, 0, 0, 0, 0, 0, $urandom, 0);
`endif
    endtask

    task automatic test_halt();
        do_fetch($urandom, 1);
        do_issue(2, 1, 1, 1, 0, 1, $urandom, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            total++;
            if ({halted, imem.imemREN, instr_valid, imem.imemaddr}
                !== {1'b1, 1'b0, 1'b0, m_pc})
                $display("FAIL halt: halted=%0b REN=%0b valid=%0b addr=%h, want 1 0 0 %h",
                         halted, imem.imemREN, instr_valid, imem.imemaddr, m_pc);
            else passed++;
            drive_junk();
            imem.ihit = 1'($urandom);
            imem.imemload_in = $urandom;
        end
`ifdef FETCH_PERF_EN
        total++;
        if ({fetch_count, wait_count} !== {32'(m_fetch), 32'(m_wait)})
            $display("FAIL halt_perf: fetch=%0d wait=%0d, want %0d %0d",
                     fetch_count, wait_count, m_fetch, m_wait);
        else passed++;
`endif
    endtask

    task automatic test_reset_mid_fetch();
        test_reset();
        goto_pc(32'h40);
        @(negedge CLK);
        drive_idle();
        total++;
        if ({imem.imemREN, imem.imemaddr} !== {1'b1, 32'h40})
            $display("FAIL pre_reset_fetch: REN=%0b addr=%h, want 1 00000040",
                     imem.imemREN, imem.imemaddr);
        else passed++;
        #2 nRST = 0;
        #1;
        total++;
        if ({imem.imemREN, imem.imemaddr, instr_valid, halted, instr}
            !== {1'b0, 32'h0, 1'b0, 1'b0, 32'h0})
            $display("FAIL async_reset: REN=%0b addr=%h valid=%0b halted=%0b instr=%h, want 0 0 0 0 0",
                     imem.imemREN, imem.imemaddr, instr_valid, halted, instr);
        else passed++;
        boot_release();
        do_fetch($urandom, 1);
        do_issue(0, 0, 0, 0, 0, 0, $urandom, 0);
        do_fetch($urandom, 0);
    endtask

    initial begin
        total = 0;
        passed = 0;
        m_pc = 0; m_instr = 0; m_fetch = 0; m_wait = 0;
        nRST = 0;
        drive_idle();
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_wrap();
        test_stall();
        test_random();
        test_halt();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
